// File: rtl/decode_issue_buf.sv
// Two-entry elastic skid buffer between decode (producer) and execute (consumer).
// Latency: a payload accepted at edge N is presented on out_data right after edge N.
// Backpressure: in_ready drops only when both entries are full; it is a pure register decode, never combinational on out_ready.
//
// Storage is a head register (always the oldest entry, drives out_data) and a
// skid register that only catches the second payload when execute stalls.
// Payloads always enter through the head when it is free or being consumed in
// the same cycle, so streaming at one payload per cycle never touches the skid.
module decode_issue_buf #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // One decoded-instruction payload.
    typedef logic [DATA_W-1:0] decode_data_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_t;

    bufState_t    state;
    bufState_t    stateNext;
    decode_data_t headReg;
    decode_data_t skidReg;

    logic inFire;
    logic outFire;
    logic acceptEvt;
    logic stallEvt;
    logic loadHeadIn;
    logic loadHeadSkid;
    logic loadSkidIn;

    // Handshake outputs decode only the state register (and reset), so execute
    // stalling never forms a combinational loop back into decode.
    assign in_ready  = (state != TWO) & ~reset;
    assign out_valid = (state != EMPTY) & ~reset;
    assign occupancy = reset ? 2'd0 : 2'(state);
    assign out_data  = headReg;

    assign inFire  = in_valid & in_ready;
    assign outFire = out_valid & out_ready;

    // A payload offered in a flush cycle belongs to the squashed path.
    assign acceptEvt = inFire & ~flush;
    assign stallEvt  = out_valid & ~out_ready;

    // Next-state and register-load decode; flush overrides all movement.
    always_comb begin
        stateNext    = state;
        loadHeadIn   = 1'b0;
        loadHeadSkid = 1'b0;
        loadSkidIn   = 1'b0;
        case (state)
            EMPTY: begin
                if (inFire) begin
                    stateNext  = ONE;
                    loadHeadIn = 1'b1;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    // Head leaves and is replaced in the same cycle.
                    stateNext  = ONE;
                    loadHeadIn = 1'b1;
                end else if (inFire) begin
                    stateNext  = TWO;
                    loadSkidIn = 1'b1;
                end else if (outFire) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the consume side can move.
                if (outFire) begin
                    stateNext    = ONE;
                    loadHeadSkid = 1'b1;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
        if (flush) begin
            stateNext    = EMPTY;
            loadHeadIn   = 1'b0;
            loadHeadSkid = 1'b0;
            loadSkidIn   = 1'b0;
        end
    end

    // State register; reset wins over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Payload registers load only on an accepted or promoted payload, so
    // in_data is never sampled while in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            headReg <= '0;
            skidReg <= '0;
        end else begin
            if (loadHeadIn) begin
                headReg <= in_data;
            end else if (loadHeadSkid) begin
                headReg <= skidReg;
            end
            if (loadSkidIn) begin
                skidReg <= in_data;
            end
        end
    end

    // Free-running statistics; wrap silently and survive flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            accept_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (acceptEvt) begin
                accept_cnt <= accept_cnt + 1'b1;
            end
            if (stallEvt) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_buf.sv
// Scoreboard bench for decode_issue_buf: queue-based reference of the buffer contents.
// Directed scenarios followed by a randomized valid/ready/flush/reset run.
// Counters run at 4 bits so wrap-around is reached quickly.
module tb_decode_issue_buf;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] accept_cnt;
    logic [CW-1:0] stall_cnt;

    decode_issue_buf #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .accept_cnt (accept_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordered list of payloads the buffer should hold.
    logic [DW-1:0] q[$];
    logic [CW-1:0] accM;
    logic [CW-1:0] stallM;
    int            cycSize;
    int            popCnt;
    int            maxOcc;
    logic          monOn;
    int            total;
    int            bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the reference, pops on consume.
    always @(negedge clk) begin
        if (monOn) begin
            cycSize = q.size();
            if (reset) begin
                chk("rst_occupancy", 64'(occupancy), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
            end else begin
                chk("occupancy", 64'(occupancy), 64'(cycSize));
                chk("out_valid", 64'(out_valid), 64'(cycSize != 0));
                chk("in_ready", 64'(in_ready), 64'(cycSize < 2));
                chk("accept_cnt", 64'(accept_cnt), 64'(accM));
                chk("stall_cnt", 64'(stall_cnt), 64'(stallM));
                if (int'(occupancy) > maxOcc) maxOcc = int'(occupancy);
                if (cycSize != 0) begin
                    chk("out_data", out_data, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        popCnt++;
                    end
                end
            end
        end
    end

    // Stimulus: drive one cycle, then record what that cycle means for the reference.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = iv ? d : {DW{1'bx}};
        out_ready = ordy;
        #6;
        // cycSize is the content count at the start of this cycle (before the pop).
        if (r) begin
            q.delete();
            accM   = '0;
            stallM = '0;
        end else begin
            if (cycSize != 0 && !ordy) stallM = stallM + 1'b1;
            if (f) begin
                q.delete();
            end else if (iv && cycSize < 2) begin
                q.push_back(d);
                accM = accM + 1'b1;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, '0, ordy);
    endtask

    task automatic doReset();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    int p0;

    initial begin
        total = 0; bad = 0; popCnt = 0; maxOcc = 0; cycSize = 0;
        accM = '0; stallM = '0; monOn = 1'b0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        doReset();
        monOn = 1'b1;
        doReset();
        idle(1'b0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // 1: stall fills both entries, third offer refused, then drain in order.
        doReset();
        p0 = popCnt;
        step(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hC, 1'b0);
        chk("t1_in_ready_full", 64'(in_ready), 64'd0);
        chk("t1_occ_full", 64'(occupancy), 64'd2);
        step(1'b0, 1'b0, 1'b1, 64'hC, 1'b1);
        step(1'b0, 1'b0, 1'b1, 64'hC, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("t1_accept_cnt", 64'(accept_cnt), 64'd3);
        chk("t1_pops", 64'(popCnt - p0), 64'd3);
        chk("t1_occ_empty", 64'(occupancy), 64'd0);

        // 2: full-rate streaming, one payload per cycle, never more than one held.
        doReset();
        p0 = popCnt;
        maxOcc = 0;
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'b1, 64'(i), 1'b1);
        idle(1'b1);
        chk("t2_pops_in_11_cycles", 64'(popCnt - p0), 64'd10);
        chk("t2_max_occ_le1", 64'(maxOcc <= 1), 64'd1);

        // 3: simultaneous push and consume in ONE.
        doReset();
        step(1'b0, 1'b0, 1'b1, 64'h5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'h6, 1'b1);
        idle(1'b0);
        chk("t3_out_data", out_data, 64'h6);
        chk("t3_occ", 64'(occupancy), 64'd1);

        // 4: flush while full with a concurrent offer.
        doReset();
        step(1'b0, 1'b0, 1'b1, 64'hA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'hB, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'hC, 1'b0);
        idle(1'b0);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_occ", 64'(occupancy), 64'd0);
        chk("t4_accept_cnt", 64'(accept_cnt), 64'd2);

        // 5: reset while full and stalled.
        doReset();
        step(1'b0, 1'b0, 1'b1, 64'h11, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'h22, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("t5_in_ready_in_reset", 64'(in_ready), 64'd0);
        idle(1'b0);
        chk("t5_occ", 64'(occupancy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_data", out_data, 64'd0);
        chk("t5_accept_cnt", 64'(accept_cnt), 64'd0);
        chk("t5_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("t5_in_ready_after", 64'(in_ready), 64'd1);

        // 6: 17 stall cycles on a 4-bit counter; each read lags one edge.
        doReset();
        step(1'b0, 1'b0, 1'b1, 64'h77, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            idle(1'b0);
            if (k == 16) chk("t6_stall_15", 64'(stall_cnt), 64'd15);
            if (k == 17) chk("t6_stall_wrap0", 64'(stall_cnt), 64'd0);
        end
        idle(1'b1);
        chk("t6_stall_wrap1", 64'(stall_cnt), 64'd1);

        // Random traffic with occasional flush and reset.
        doReset();
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom},
                 ($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 4; n++) idle(1'b1);
        chk("rand_drained", 64'(q.size()), 64'd0);

        monOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
